// File: rtl/bram_dp_param.sv
// Parametrised true-dual-port block RAM on one clock: per-bit write masks, selectable read-during-write, optional output register.
// Optional post-reset clear sequencer is compiled in when BRAM_DP_CLEAR_EN is defined.
module bram_dp_param #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 8192,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AWIDTH-1:0] A0,
    input  logic [WIDTH-1:0]  D0,
    output logic [WIDTH-1:0]  Q0,
    input  logic              WE0,
    input  logic [WIDTH-1:0]  WEM0,
    input  logic              CE0,
    input  logic [AWIDTH-1:0] A1,
    input  logic [WIDTH-1:0]  D1,
    output logic [WIDTH-1:0]  Q1,
    input  logic              WE1,
    input  logic [WIDTH-1:0]  WEM1,
    input  logic              CE1,
    output logic              RDY
);

    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              rdy;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic              en0, en1, ok0, ok1, wr0, wr1, same;
    logic [WIDTH-1:0]  old0, old1, merge0, merge1, wdat0, rd0, rd1;
    logic [WIDTH-1:0]  q0_s1, q1_s1;

`ifdef BRAM_DP_CLEAR_EN
    // state | meaning
    // IDLE  | held in reset, clear counter at 0
    // CLEAR | writing zero to counter address, one word per cycle
    // READY | memory accepts external accesses
    typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;
    state_t            state, state_nxt;
    logic [AWIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) state_nxt = READY;
            end
            READY:   state_nxt = READY;
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;
    assign rdy      = (state == READY);
`else
    always_ff @(posedge CLK) begin
        if (RST) rdy <= 1'b0;
        else     rdy <= 1'b1;
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign RDY = rdy;

    assign ok0  = {1'b0, A0} < DEPTH_W;
    assign ok1  = {1'b0, A1} < DEPTH_W;
    assign en0  = CE0 & rdy & ~RST;
    assign en1  = CE1 & rdy & ~RST;
    assign wr0  = en0 & WE0 & ok0;
    assign wr1  = en1 & WE1 & ok1;
    assign same = (A0 == A1);

    assign old0   = ok0 ? mem[A0] : '0;
    assign old1   = ok1 ? mem[A1] : '0;
    assign merge0 = (old0 & ~WEM0) | (D0 & WEM0);
    assign merge1 = (old1 & ~WEM1) | (D1 & WEM1);
    // On a same-address double write, port 0 overlays its masked bits onto port 1's result.
    assign wdat0  = (wr1 && same) ? ((merge1 & ~WEM0) | (D0 & WEM0)) : merge0;

    assign rd0 = (RDW_MODE != 0 && wr0) ? merge0 : old0;
    assign rd1 = (RDW_MODE != 0 && wr1) ? merge1 : old1;

    always_ff @(posedge CLK) begin
        if (wr1 && !(wr0 && same)) mem[A1] <= wdat1_sel();
        if (wr0)                   mem[A0] <= wdat0;
        if (clr_we)                mem[clr_addr] <= '0;
    end

    function automatic logic [WIDTH-1:0] wdat1_sel();
        return merge1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            q0_s1 <= '0;
            q1_s1 <= '0;
        end else begin
            if (en0) q0_s1 <= rd0;
            if (en1) q1_s1 <= rd1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] q0_s2, q1_s2;
            logic             ld0, ld1;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    q0_s2 <= '0;
                    q1_s2 <= '0;
                    ld0   <= 1'b0;
                    ld1   <= 1'b0;
                end else begin
                    ld0 <= en0;
                    ld1 <= en1;
                    if (ld0) q0_s2 <= q0_s1;
                    if (ld1) q1_s2 <= q1_s1;
                end
            end

            assign Q0 = q0_s2;
            assign Q1 = q1_s2;
        end else begin : g_noreg
            assign Q0 = q0_s1;
            assign Q1 = q1_s1;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: two instances (read-first/no output reg, write-first/output reg) driven in lockstep,
// checked against an array-based reference memory with per-port read and pipeline tracking.
module tb_bram_dp_param;

    localparam int DEP = 10;
`ifdef BRAM_DP_CLEAR_EN
    localparam int LAT = DEP + 1;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] A0 = '0, A1 = '0;
    logic [7:0] D0 = '0, D1 = '0, WEM0 = '0, WEM1 = '0;
    logic       CE0 = 1'b0, CE1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [7:0] qa0, qa1, qb0, qb1;
    logic       rdya, rdyb;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [DEP];
    logic [7:0] ea0 = '0, ea1 = '0;
    logic [7:0] bs1_0 = '0, bs1_1 = '0, bs2_0 = '0, bs2_1 = '0;
    bit         bld0 = 0, bld1 = 0;

    bram_dp_param #(.WIDTH(8), .DEPTH(DEP), .OUT_REG(0), .RDW_MODE(0)) dut_a (
        .CLK(CLK), .RST(RST),
        .A0(A0), .D0(D0), .Q0(qa0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0),
        .A1(A1), .D1(D1), .Q1(qa1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1),
        .RDY(rdya)
    );

    bram_dp_param #(.WIDTH(8), .DEPTH(DEP), .OUT_REG(1), .RDW_MODE(1)) dut_b (
        .CLK(CLK), .RST(RST),
        .A0(A0), .D0(D0), .Q0(qb0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0),
        .A1(A1), .D1(D1), .Q1(qb1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1),
        .RDY(rdyb)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Word a port returns: zero out of range, merged word for a write-first self-write, else stored word.
    function automatic logic [7:0] rdv(input logic [3:0] a, input logic w, input logic [7:0] d,
                                       input logic [7:0] m, input bit wf);
        if (int'(a) >= DEP) return 8'h00;
        if (wf && w) return (mm[a] & ~m) | (d & m);
        return mm[a];
    endfunction

    task automatic cycle(input logic c0, input logic w0, input logic [3:0] ad0, input logic [7:0] d0,
                         input logic [7:0] m0, input logic c1, input logic w1, input logic [3:0] ad1,
                         input logic [7:0] d1, input logic [7:0] m1);
        CE0 = c0; WE0 = w0; A0 = ad0; D0 = d0; WEM0 = m0;
        CE1 = c1; WE1 = w1; A1 = ad1; D1 = d1; WEM1 = m1;
        if (bld0) bs2_0 = bs1_0;
        if (bld1) bs2_1 = bs1_1;
        if (c0) begin
            ea0   = rdv(ad0, w0, d0, m0, 0);
            bs1_0 = rdv(ad0, w0, d0, m0, 1);
        end
        if (c1) begin
            ea1   = rdv(ad1, w1, d1, m1, 0);
            bs1_1 = rdv(ad1, w1, d1, m1, 1);
        end
        bld0 = c0;
        bld1 = c1;
        if (c1 && w1 && int'(ad1) < DEP) mm[ad1] = (mm[ad1] & ~m1) | (d1 & m1);
        if (c0 && w0 && int'(ad0) < DEP) mm[ad0] = (mm[ad0] & ~m0) | (d0 & m0);
        @(posedge CLK);
        @(negedge CLK);
        chk("a_q0", qa0, ea0);
        chk("a_q1", qa1, ea1);
        chk("b_q0", qb0, bs2_0);
        chk("b_q1", qb1, bs2_1);
        chk("rdy", {7'b0, rdya & rdyb}, 8'h01);
    endtask

    task automatic do_reset(input int restart_at);
        int n;
        bit done;
        RST = 1'b1; CE0 = 1'b1; WE0 = 1'b0; CE1 = 1'b1; WE1 = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_a_q0", qa0, 8'h00);
        chk("rst_a_q1", qa1, 8'h00);
        chk("rst_b_q0", qb0, 8'h00);
        chk("rst_b_q1", qb1, 8'h00);
        chk("rst_rdy", {7'b0, rdya | rdyb}, 8'h00);
        ea0 = '0; ea1 = '0; bs1_0 = '0; bs1_1 = '0; bs2_0 = '0; bs2_1 = '0;
        bld0 = 0; bld1 = 0;
        RST = 1'b0;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            CE0 = 1'b1; WE0 = 1'b1; A0 = 4'($urandom_range(0, DEP-1)); D0 = 8'($urandom); WEM0 = 8'hFF;
            CE1 = 1'b1; WE1 = 1'b1; A1 = 4'($urandom_range(0, DEP-1)); D1 = 8'($urandom); WEM1 = 8'hFF;
            @(posedge CLK);
            @(negedge CLK);
            n++;
            chk("ign_a_q0", qa0, 8'h00);
            chk("ign_b_q1", qb1, 8'h00);
            if (rdya === 1'b1) done = 1;
            else if (n == restart_at) begin
                RST = 1'b1; WE0 = 1'b0; WE1 = 1'b0;
                @(posedge CLK);
                @(negedge CLK);
                chk("restart_rdy", {7'b0, rdya}, 8'h00);
                RST = 1'b0;
                n = 0;
                restart_at = 0;
            end
        end
        chk_n("rdy_latency", n, LAT);
        chk("rdy_b", {7'b0, rdyb}, 8'h01);
`ifdef BRAM_DP_CLEAR_EN
        for (int i = 0; i < DEP; i++) mm[i] = 8'h00;
`endif
        CE0 = 1'b0; WE0 = 1'b0; CE1 = 1'b0; WE1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEP; i++) mm[i] = 8'h00;
        @(negedge CLK);
        do_reset(0);

        for (int i = 0; i < DEP; i++)
            cycle(1, 1, 4'(i), 8'($urandom), 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);

        // masked write
        cycle(1, 1, 4'd5, 8'hFF, 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
        cycle(1, 1, 4'd5, 8'h00, 8'h0F, 0, 0, 4'd0, 8'h00, 8'h00);
        cycle(1, 0, 4'd5, 8'h00, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);
        chk("masked", qa0, 8'hF0);

        // same-port read-during-write
        cycle(1, 1, 4'd3, 8'h11, 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
        cycle(1, 1, 4'd3, 8'h22, 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
        chk("rdw_old", qa0, 8'h11);
        cycle(0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);
        chk("rdw_new", qb0, 8'h22);

        // both ports writing one address
        cycle(1, 1, 4'd7, 8'hAA, 8'hF0, 1, 1, 4'd7, 8'h55, 8'hFF);
        cycle(1, 0, 4'd7, 8'h00, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);
        chk("collide", qa0, 8'hA5);

        // output register latency
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 4'(i), 8'(10 + i), 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
        cycle(0, 0, 4'd0, 8'h00, 8'h00, 1, 0, 4'd0, 8'h00, 8'h00);
        for (int i = 1; i < 5; i++) begin
            cycle(0, 0, 4'd0, 8'h00, 8'h00, i < 4, 0, 4'(i % 4), 8'h00, 8'h00);
            chk("oreg_seq", qb1, 8'(9 + i));
        end

        // out-of-range address
        cycle(1, 1, 4'd12, 8'h77, 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
        cycle(1, 0, 4'd12, 8'h00, 8'h00, 1, 0, 4'd12, 8'h00, 8'h00);
        chk("oor_read", qa0, 8'h00);

        repeat (300) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 11)), 8'($urandom),
                  $urandom_range(0, 1) != 0 ? 8'hFF : 8'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 11)), 8'($urandom),
                  $urandom_range(0, 1) != 0 ? 8'hFF : 8'($urandom));
        end

        // reset with reads in flight, then confirm contents
        cycle(1, 0, 4'd1, 8'h00, 8'h00, 1, 0, 4'd2, 8'h00, 8'h00);
        do_reset(8);
        for (int i = 0; i < DEP; i++)
            cycle(1, 0, 4'(i), 8'h00, 8'h00, 1, 0, 4'(DEP - 1 - i), 8'h00, 8'h00);
        cycle(0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
